sd_sector_buffer: RTL

Double-buffered (ping-pong) sector store downstream of `sd_card_reader`. It captures the reader's `data_out`/`data_valid` byte stream into two 512-byte banks. Each completed bank is handed to a consumer (display/loader logic) through a random-access read port and a release handshake. Because the reader has no backpressure, the buffer detects bytes that arrive while no bank is free and flags them as a sticky overrun.

---
 rtl/sd_sector_buffer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/sd_sector_buffer.sv
`default_nettype none
// ============================================================================
// Module   : sd_sector_buffer
// Purpose  : Ping-pong 2 x SECTOR_BYTES sector store fed by the SD card
//            reader byte stream. Completed banks are exposed through a
//            registered random-access read port and freed with a release
//            pulse. Bytes arriving with no free bank set a sticky overrun.
// Options  : define SD_BUF_CHECKSUM_EN to build per-bank 16-bit byte sums
//            shown on checksum_o; otherwise checksum_o is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module sd_sector_buffer #(
  parameter int SECTOR_BYTES = 512,
  parameter int ADDR_W       = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic              bank_ready_o,
  output logic              bank_sel_o,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [7:0]        rd_data_o,
  input  logic              release_i,
  output logic [15:0]       sectors_done_o,
  output logic              overrun_o,
  output logic [15:0]       checksum_o
);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_FILLING = 2'd1,
    ST_FULL    = 2'd2
  } bank_state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(SECTOR_BYTES - 1);

  bank_state_t       bank_st_q [2];
  logic              wr_bank_q;
  logic              rd_bank_q;
  logic [ADDR_W-1:0] wr_cnt_q;
  logic [ADDR_W-1:0] wr_cnt_d;
  logic [15:0]       sectors_done_q;
  logic [15:0]       sectors_done_d;
  logic              overrun_q;
  logic [7:0]        rd_data_q;

  // Both banks share one array; the bank index is the top address bit.
  logic [7:0]        mem_q [2*SECTOR_BYTES];

  logic              w_accept;
  logic              w_last;
  logic              w_release;
  logic              w_drop;

  // Flow-control flags depend only on state registers.
  assign in_ready_o   = (bank_st_q[wr_bank_q] != ST_FULL);
  assign bank_ready_o = (bank_st_q[rd_bank_q] == ST_FULL);
  assign bank_sel_o   = rd_bank_q;

  assign w_accept  = in_valid_i && in_ready_o;
  assign w_drop    = in_valid_i && !in_ready_o;
  assign w_last    = w_accept && (wr_cnt_q == LAST_IDX);
  assign w_release = release_i && bank_ready_o;

  // Power-of-two sector size: the counter wraps to 0 on the last byte.
  assign wr_cnt_d       = wr_cnt_q + ADDR_W'(1);
  assign sectors_done_d = sectors_done_q + 16'd1;

  // Bank state machine, write pointer, read bank, counters and overrun.
  // Completion and release never target the same bank in one cycle, since
  // a bank being completed is not FULL and therefore cannot be released.
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_st_q[0]   <= ST_EMPTY;
      bank_st_q[1]   <= ST_EMPTY;
      wr_bank_q      <= 1'b0;
      rd_bank_q      <= 1'b0;
      wr_cnt_q       <= '0;
      sectors_done_q <= 16'd0;
      overrun_q      <= 1'b0;
    end else begin
      if (w_accept) begin
        wr_cnt_q <= wr_cnt_d;
        if (w_last) begin
          bank_st_q[wr_bank_q] <= ST_FULL;
          wr_bank_q            <= ~wr_bank_q;
          sectors_done_q       <= sectors_done_d;
        end else begin
          bank_st_q[wr_bank_q] <= ST_FILLING;
        end
      end
      if (w_release) begin
        bank_st_q[rd_bank_q] <= ST_EMPTY;
        rd_bank_q            <= ~rd_bank_q;
      end
      if (w_drop) begin
        overrun_q <= 1'b1;
      end
    end
  end

  // Sector storage write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      mem_q[{wr_bank_q, wr_cnt_q}] <= in_data_i;
    end
  end

  // Registered read port, one cycle latency from rd_addr_i.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= 8'h00;
    end else begin
      rd_data_q <= mem_q[{rd_bank_q, rd_addr_i}];
    end
  end

  assign rd_data_o      = rd_data_q;
  assign sectors_done_o = sectors_done_q;
  assign overrun_o      = overrun_q;

`ifdef SD_BUF_CHECKSUM_EN
  logic [15:0] sum_q [2];

  // Per-bank running byte sum, restarted by the first byte of a sector.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q[0] <= 16'h0000;
      sum_q[1] <= 16'h0000;
    end else if (w_accept) begin
      sum_q[wr_bank_q] <= ((bank_st_q[wr_bank_q] == ST_EMPTY) ? 16'h0000 : sum_q[wr_bank_q])
                          + {8'h00, in_data_i};
    end
  end

  assign checksum_o = sum_q[rd_bank_q];
`else
  assign checksum_o = 16'h0000;
`endif

endmodule
`default_nettype wire
